// File: rtl/dct32_odd_mac_sched.sv
// Serial scheduler for the odd half of a 32-point DCT-II.
// Samples d[0..15] are fed one per cycle to a shared constant multiplier; the
// returned coefficient multiples are routed with the right sign into 16 row
// accumulators, and the finished rows y[0..15] are streamed out in order.
//
// state | meaning
// ------+------------------------------------------------------------
// LOAD  | accept d[k]; each accepted sample is multiplied next cycle
// DRAIN | no input; accumulates the product of d[15]
// OUT   | stream fmt(acc[oi]) with a valid/ready handshake
module dct32_odd_mac_sched #(
    parameter int ACC_W = 28,
    parameter int SHIFT = 0,
    parameter int OUT_W = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [16:0]      in_data,
    output logic signed [16:0]      mult_x,
    input  logic [404:0]            prod_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [3:0]              out_idx,
    output logic                    busy
);

    typedef enum logic [1:0] {LOAD, DRAIN, OUT} state_t;

    state_t state, state_nxt;
    logic [3:0] k;
    logic [3:0] kd;
    logic       pv;
    logic [3:0] oi;
    logic [3:0] oi_sel;
    logic       in_acc;
    logic       out_acc;

    logic signed [ACC_W-1:0] acc  [16];
    logic signed [ACC_W-1:0] term [16];

    logic signed [ACC_W-1:0] acc_sel;
    logic signed [ACC_W:0]   rnd;
    logic signed [OUT_W-1:0] fmt_v;

    // Half an output LSB, used for round-half-up; zero when there is no shift.
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'((1 << SHIFT) >> 1);

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;
    assign out_idx = oi;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs; in_ready is forced low in reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD: begin
                in_ready = rst_n;
                if (in_acc && k == 4'd15) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                busy = 1'b1;
                if (out_acc && oi == 4'd15) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Input capture: operand register, sample index and one-cycle product-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_x <= '0;
            k      <= '0;
            kd     <= '0;
            pv     <= 1'b0;
        end else if (in_acc) begin
            mult_x <= in_data;
            kd     <= k;
            pv     <= 1'b1;
            k      <= k + 4'd1;
        end else begin
            pv <= 1'b0;
        end
    end

    // Per-row coefficient routing: fold (2i+1)(2kd+1) mod 128 onto the first
    // quarter wave to get the product slot and sign. j=1 and j=3 share slot 14.
    always_comb begin
        logic [9:0]         pa;
        logic [6:0]         a;
        logic [4:0]         j;
        logic [3:0]         m;
        logic [3:0]         slot;
        logic signed [26:0] p;
        pa   = '0;
        a    = '0;
        j    = '0;
        m    = '0;
        slot = '0;
        p    = '0;
        for (int i = 0; i < 16; i++) begin
            pa = 10'(2 * i + 1) * {5'd0, kd, 1'b1};
            a  = pa[6:0];
            case (a[6:5])
                2'b00:   j = a[4:0];
                2'b01:   j = 5'(7'd64 - a);
                2'b10:   j = a[4:0];
                default: j = 5'(7'd0 - a);
            endcase
            m       = j[4:1];
            slot    = (m == 4'd0) ? 4'd14 : 4'd15 - m;
            p       = prod_bus[27*slot +: 27];
            term[i] = (a[6] ^ a[5]) ? -ACC_W'(p) : ACC_W'(p);
        end
    end

    // Row accumulators; the product of d[0] restarts every row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) acc[i] <= '0;
        end else if (pv) begin
            for (int i = 0; i < 16; i++)
                acc[i] <= ((kd == 4'd0) ? '0 : acc[i]) + term[i];
        end
    end

    // Row that the output register loads next: current one on entry, else the following one.
    always_comb begin
        oi_sel = out_valid ? oi + 4'd1 : oi;
    end

    assign acc_sel = acc[oi_sel];
    assign rnd     = ($signed({acc_sel[ACC_W-1], acc_sel}) + HALF) >>> SHIFT;

    generate
        if (OUT_W >= ACC_W + 1) begin : g_nosat
            assign fmt_v = OUT_W'(rnd);
        end else begin : g_sat
            localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'({1'b0, {(OUT_W-1){1'b1}}});
            localparam logic signed [ACC_W:0] SMIN = ~SMAX;
            assign fmt_v = (rnd > SMAX) ? SMAX[OUT_W-1:0] :
                           (rnd < SMIN) ? SMIN[OUT_W-1:0] : rnd[OUT_W-1:0];
        end
    endgenerate

    // Output register: filled one cycle after entering OUT, advanced on each accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            oi        <= '0;
        end else if (state == OUT) begin
            if (out_acc && oi == 4'd15) begin
                out_valid <= 1'b0;
                oi        <= '0;
            end else if (!out_valid || out_acc) begin
                out_valid <= 1'b1;
                out_data  <= fmt_v;
                oi        <= oi_sel;
            end
        end
    end

endmodule

// File: tb/tb_dct32_odd_mac_sched.sv
// Bench for dct32_odd_mac_sched: three parameterisations run in lockstep from
// the same stimulus, each checked against a DCT matrix built from cosine signs.
module tb_dct32_odd_mac_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [16:0] in_data = '0;

    logic in_ready_a, in_ready_b, in_ready_c;
    logic signed [16:0] mx_a, mx_b, mx_c;
    logic [404:0] pb_a, pb_b, pb_c;
    logic out_valid_a, out_valid_b, out_valid_c;
    logic signed [27:0] od_a;
    logic signed [15:0] od_b, od_c;
    logic [3:0] oidx_a, oidx_b, oidx_c;
    logic busy_a, busy_b, busy_c;

    int checks = 0;
    int failures = 0;

    localparam int COEF [15] = '{4, 13, 22, 31, 38, 46, 54, 61, 67, 73, 78, 82, 85, 88, 90};
    localparam int MAG  [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};

    int gm [16][16];
    int d [16];
    longint y [16];
    longint got [16];
    longint saved [16];

    always #5 clk = ~clk;

    function automatic logic [404:0] mults(input logic signed [16:0] x);
        logic [404:0] r;
        r = '0;
        for (int s = 0; s < 15; s++) r[27*s +: 27] = 27'(longint'(x) * COEF[s]);
        return r;
    endfunction

    assign pb_a = mults(mx_a);
    assign pb_b = mults(mx_b);
    assign pb_c = mults(mx_c);

    dct32_odd_mac_sched #(.ACC_W(28), .SHIFT(0), .OUT_W(28)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .mult_x(mx_a), .prod_bus(pb_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(od_a), .out_idx(oidx_a), .busy(busy_a));

    dct32_odd_mac_sched #(.ACC_W(28), .SHIFT(7), .OUT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .mult_x(mx_b), .prod_bus(pb_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(od_b), .out_idx(oidx_b), .busy(busy_b));

    dct32_odd_mac_sched #(.ACC_W(28), .SHIFT(0), .OUT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .mult_x(mx_c), .prod_bus(pb_c), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_data(od_c), .out_idx(oidx_c), .busy(busy_c));

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Row i, column k of the odd DCT: magnitude from the folded angle, sign from cos.
    task automatic build_matrix();
        int a, j;
        real c;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 16; k++) begin
                a = ((2*i + 1) * (2*k + 1)) % 128;
                j = a % 64;
                if (j > 32) j = 64 - j;
                c = $cos(3.14159265358979 * real'(a) / 64.0);
                gm[i][k] = (c > 0.0) ? MAG[(j-1)/2] : -MAG[(j-1)/2];
            end
        end
    endtask

    function automatic longint fmtm(input longint v, input int sh, input int ow);
        longint r, hi, lo;
        r = v;
        if (sh > 0) r = (r + (longint'(1) << (sh - 1))) >>> sh;
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic model();
        for (int i = 0; i < 16; i++) begin
            y[i] = 0;
            for (int k = 0; k < 16; k++) y[i] += longint'(d[k]) * gm[i][k];
        end
    endtask

    task automatic send(input int nsend, input bit gaps);
        bit rd;
        int guard;
        for (int k = 0; k < nsend; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 17'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = 17'(d[k]);
            guard = 0;
            rd = 1'b0;
            while (!rd && guard < 100) begin
                rd = in_ready_a;
                @(posedge clk); #1;
                guard++;
            end
            if (!rd) chk("in_ready_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input int stall_at, input int stall_len, input bit rgaps);
        int guard;
        logic signed [27:0] hold_d;
        logic [3:0] hold_i;
        for (int i = 0; i < 16; i++) begin
            guard = 0;
            while (!out_valid_a && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            chk("out_valid_timeout", out_valid_a, 1);
            chk("out_idx", oidx_a, i);
            chk("y_a", od_a, fmtm(y[i], 0, 28));
            chk("y_b_shift7", od_b, fmtm(y[i], 7, 16));
            chk("y_c_sat16", od_c, fmtm(y[i], 0, 16));
            chk("in_ready_out", in_ready_a, 0);
            got[i] = od_a;
            if (i == stall_at || (rgaps && $urandom_range(0, 3) == 0)) begin
                hold_d = od_a;
                hold_i = oidx_a;
                out_ready = 1'b0;
                repeat ((i == stall_at) ? stall_len : 1 + $urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    chk("stall_data", od_a, hold_d);
                    chk("stall_idx", oidx_a, hold_i);
                    chk("stall_in_ready", in_ready_a, 0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("done_valid", out_valid_a, 0);
        chk("done_busy", busy_a, 0);
        chk("mult_x_hold", mx_a, d[15]);
    endtask

    task automatic run_block(input bit gaps, input int stall_at, input int stall_len, input bit rgaps);
        model();
        send(16, gaps);
        chk("lat_e0_valid", out_valid_a, 0);
        chk("lat_e0_busy", busy_a, 1);
        @(posedge clk); #1;
        chk("lat_e1_valid", out_valid_a, 0);
        @(posedge clk); #1;
        chk("lat_e2_valid", out_valid_a, 1);
        recv(stall_at, stall_len, rgaps);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        build_matrix();
        #2;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_out_data", od_a, 0);
        chk("rst_out_idx", oidx_a, 0);
        chk("rst_mult_x", mx_a, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready_a, 1);

        for (int k = 0; k < 16; k++) d[k] = (k == 0) ? 1 : 0;
        run_block(1'b0, -1, 0, 1'b0);

        for (int k = 0; k < 16; k++) d[k] = (k == 1) ? 1 : 0;
        run_block(1'b0, -1, 0, 1'b0);
        chk("imp1_y15", got[15], -13);

        for (int k = 0; k < 16; k++) d[k] = -65536;
        run_block(1'b0, -1, 0, 1'b0);
        chk("neg_full_y0", got[0], -60424192);

        for (int k = 0; k < 16; k++) d[k] = 65535;
        run_block(1'b0, -1, 0, 1'b0);

        for (int k = 0; k < 16; k++) d[k] = int'($urandom_range(0, 131071)) - 65536;
        run_block(1'b1, 3, 5, 1'b0);
        for (int i = 0; i < 16; i++) saved[i] = got[i];
        run_block(1'b0, -1, 0, 1'b0);
        for (int i = 0; i < 16; i++) chk("gap_vs_nogap", got[i], saved[i]);

        for (int k = 0; k < 16; k++) d[k] = 65535 - k;
        model();
        send(7, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid_a, 0);
        chk("abort_in_ready", in_ready_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_out_data", od_a, 0);
        chk("abort_out_idx", oidx_a, 0);
        chk("abort_mult_x", mx_a, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) d[k] = int'($urandom_range(0, 131071)) - 65536;
        run_block(1'b0, -1, 0, 1'b0);

        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 16; k++) d[k] = int'($urandom_range(0, 131071)) - 65536;
            run_block(1'b1, -1, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
